// File: rtl/layer_argmax_if.sv
// Result bus between the argmax stage and its host: network completion and
// neuron outputs in, classification result and status out.
interface layer_argmax_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_UNITS  = 4,
    parameter int IDX_WIDTH  = 2
);
    logic                            done;
    logic [NUM_UNITS*DATA_WIDTH-1:0] layer_out;
    logic                            result_ack;
    logic                            result_valid;
    logic [IDX_WIDTH-1:0]            result_idx;
    logic [DATA_WIDTH-1:0]           result_val;
    logic [DATA_WIDTH-1:0]           result_margin;
    logic                            busy;
    logic                            overrun;
    logic [7:0]                      result_count;

    modport master (
        output done, layer_out, result_ack,
        input  result_valid, result_idx, result_val, result_margin,
               busy, overrun, result_count
    );

    modport slave (
        input  done, layer_out, result_ack,
        output result_valid, result_idx, result_val, result_margin,
               busy, overrun, result_count
    );
endinterface

// File: rtl/layer_argmax.sv
// Snapshots the final-layer outputs on a rising done, scans one unit per cycle
// for winner, value and margin over runner-up, and holds the result until acked.
module layer_argmax #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_UNITS  = 4,
    parameter int IDX_WIDTH  = 2
) (
    input  logic           clk,
    input  logic           reset,
    layer_argmax_if.slave  bus
);
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH-1:0]         LAST_IDX = IDX_WIDTH'(NUM_UNITS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, VALID} state_t;

    state_t                        state_reg;
    logic                          done_q_reg;
    logic                          done_event;
    logic                          capture;
    logic signed [DATA_WIDTH-1:0]  unit_in  [NUM_UNITS];
    logic signed [DATA_WIDTH-1:0]  snap_reg [NUM_UNITS];
    logic [IDX_WIDTH-1:0]          cnt_reg;
    logic signed [DATA_WIDTH-1:0]  cur_val;
    logic signed [DATA_WIDTH-1:0]  best_reg, best_next;
    logic signed [DATA_WIDTH-1:0]  second_reg, second_next;
    logic [IDX_WIDTH-1:0]          best_idx_reg, best_idx_next;
    logic [DATA_WIDTH-1:0]         margin_next;

    logic                          valid_reg;
    logic [IDX_WIDTH-1:0]          idx_reg;
    logic [DATA_WIDTH-1:0]         val_reg;
    logic [DATA_WIDTH-1:0]         margin_reg;
    logic                          busy_reg;
    logic                          overrun_reg;
    logic [7:0]                    count_reg;

    // done_q resets high so a done level held through reset is not an event.
    assign done_event = bus.done && !done_q_reg;
    assign capture    = done_event && (state_reg == IDLE) && !reset;

    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_snap
            assign unit_in[gi] = bus.layer_out[gi*DATA_WIDTH +: DATA_WIDTH];

            always_ff @(posedge clk) begin
                if (capture) begin
                    snap_reg[gi] <= unit_in[gi];
                end
            end
        end
    endgenerate

    assign cur_val = snap_reg[cnt_reg];

    always_comb begin
        best_next     = best_reg;
        second_next   = second_reg;
        best_idx_next = best_idx_reg;
        if (cnt_reg == '0) begin
            best_next     = cur_val;
            second_next   = MOST_NEG;
            best_idx_next = '0;
        end else if (cur_val > best_reg) begin
            second_next   = best_reg;
            best_next     = cur_val;
            best_idx_next = cnt_reg;
        end else if (cur_val > second_reg) begin
            second_next   = cur_val;
        end
    end

    // best >= second always holds, so the true difference is non-negative and
    // fits DATA_WIDTH unsigned bits; the low bits of the wide result are exact.
    assign margin_next = best_next - second_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            done_q_reg   <= 1'b1;
            cnt_reg      <= '0;
            best_reg     <= '0;
            second_reg   <= '0;
            best_idx_reg <= '0;
            valid_reg    <= 1'b0;
            idx_reg      <= '0;
            val_reg      <= '0;
            margin_reg   <= '0;
            busy_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
            count_reg    <= '0;
        end else begin
            done_q_reg <= bus.done;
            if (done_event && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (done_event) begin
                        state_reg <= SCAN;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                SCAN: begin
                    best_reg     <= best_next;
                    second_reg   <= second_next;
                    best_idx_reg <= best_idx_next;
                    cnt_reg      <= cnt_reg + IDX_WIDTH'(1);
                    if (cnt_reg == LAST_IDX) begin
                        idx_reg    <= best_idx_next;
                        val_reg    <= best_next;
                        margin_reg <= margin_next;
                        valid_reg  <= 1'b1;
                        state_reg  <= VALID;
                    end
                end
                VALID: begin
                    if (bus.result_ack) begin
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        count_reg <= count_reg + 8'd1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.result_valid  = valid_reg;
    assign bus.result_idx    = idx_reg;
    assign bus.result_val    = val_reg;
    assign bus.result_margin = margin_reg;
    assign bus.busy          = busy_reg;
    assign bus.overrun       = overrun_reg;
    assign bus.result_count  = count_reg;
endmodule

// File: tb/tb_layer_argmax.sv
// Self-checking bench for layer_argmax: scoreboarded classifications, handshake,
// overrun and reset behaviour.
module tb_layer_argmax;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    layer_argmax_if #(.DATA_WIDTH(32), .NUM_UNITS(4), .IDX_WIDTH(2)) bus ();

    layer_argmax #(.DATA_WIDTH(32), .NUM_UNITS(4), .IDX_WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] val;
        logic [31:0] margin;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   exp_count = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first strictly-greater max wins; runner-up is the max of the rest.
    function automatic exp_t model(input int a, input int b, input int c, input int d);
        int   v[4];
        int   w;
        int   r;
        exp_t e;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        w = 0;
        for (int i = 1; i < 4; i++) if (v[i] > v[w]) w = i;
        r = int'(32'h8000_0000);
        for (int i = 0; i < 4; i++) if (i != w && v[i] > r) r = v[i];
        e.idx    = 2'(w);
        e.val    = v[w];
        e.margin = v[w] - r;
        return e;
    endfunction

    // Drops done for one edge, then presents values with done high; returns after edge k.
    task automatic fire(input int a, input int b, input int c, input int d);
        bus.done = 1'b0;
        tick();
        bus.layer_out = {d, c, b, a};
        bus.done = 1'b1;
        sb.push_back(model(a, b, c, d));
        tick();
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (bus.result_valid !== 1'b1 && cycles < 30) begin
            tick();
            cycles++;
        end
        if (bus.result_valid !== 1'b1) cycles = -1;
    endtask

    task automatic test_reset();
        bus.done = 1'b0;
        bus.result_ack = 1'b0;
        bus.layer_out = '0;
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.result_valid); end
        n_checks++; if (bus.result_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", bus.result_idx); end
        n_checks++; if (bus.result_val !== 32'd0) begin n_fail++; $display("FAIL reset_val got %0h want 0", bus.result_val); end
        n_checks++; if (bus.result_margin !== 32'd0) begin n_fail++; $display("FAIL reset_margin got %0h want 0", bus.result_margin); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %0b want 0", bus.overrun); end
        n_checks++; if (bus.result_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.result_count); end
        reset = 1'b0;
        tick();
        $display("reset: outputs idle");
    endtask

    task automatic test_classify(input int a, input int b, input int c, input int d,
                                 input string name, input bit change_mid);
        int   cyc;
        exp_t e;
        fire(a, b, c, d);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy got %0b want 1", name, bus.busy); end
        if (change_mid) bus.layer_out = ~bus.layer_out;
        wait_valid(cyc);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL %s_latency got %0d want 4", name, cyc); end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++; $display("FAIL %s_scoreboard got empty want 1 entry", name);
        end else begin
            e = sb.pop_front();
            n_checks++; if (bus.result_idx !== e.idx) begin n_fail++; $display("FAIL %s_idx got %0d want %0d", name, bus.result_idx, e.idx); end
            n_checks++; if (bus.result_val !== e.val) begin n_fail++; $display("FAIL %s_val got %0h want %0h", name, bus.result_val, e.val); end
            n_checks++; if (bus.result_margin !== e.margin) begin n_fail++; $display("FAIL %s_margin got %0h want %0h", name, bus.result_margin, e.margin); end
        end
        $display("result %s: idx=%0d val=%0h margin=%0h", name, bus.result_idx, bus.result_val, bus.result_margin);
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        exp_count = (exp_count + 1) % 256;
        n_checks++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL %s_ack_valid got %0b want 0", name, bus.result_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s_ack_busy got %0b want 0", name, bus.busy); end
        n_checks++; if (bus.result_count !== 8'(exp_count)) begin n_fail++; $display("FAIL %s_count got %0d want %0d", name, bus.result_count, exp_count); end
    endtask

    task automatic test_hold_ack();
        int   cyc;
        exp_t e;
        fire(3, -1, 100, -50);
        wait_valid(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL hold_valid_timeout got %0d want >=0", cyc); end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if ({bus.result_valid, bus.result_idx, bus.result_val, bus.result_margin} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL hold_stable cycle %0d got v=%0b %0d %0h %0h want v=1 %0d %0h %0h", i,
                         bus.result_valid, bus.result_idx, bus.result_val, bus.result_margin, e.idx, e.val, e.margin);
            end
        end
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        exp_count = (exp_count + 1) % 256;
        n_checks++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL hold_ack_valid got %0b want 0", bus.result_valid); end
        n_checks++; if (bus.result_count !== 8'(exp_count)) begin n_fail++; $display("FAIL hold_count got %0d want %0d", bus.result_count, exp_count); end
        $display("hold: idx=%0d val=%0h margin=%0h held 20 cycles", e.idx, e.val, e.margin);
    endtask

    task automatic test_ack_idle();
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        tick();
        n_checks++; if (bus.result_count !== 8'(exp_count)) begin n_fail++; $display("FAIL idle_ack_count got %0d want %0d", bus.result_count, exp_count); end
        n_checks++; if ({bus.result_valid, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL idle_ack_state got %b want 00", {bus.result_valid, bus.busy}); end
        $display("idle ack: count=%0d", bus.result_count);
    endtask

    task automatic test_overrun();
        int   cyc;
        bit   saw;
        exp_t e;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        exp_count = 0;
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %0b want 0", bus.overrun); end
        fire(1, 2, 3, 4);
        bus.done = 1'b0;
        tick();
        bus.done = 1'b1;
        tick();
        n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_scan got %0b want 1", bus.overrun); end
        wait_valid(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL ovr_valid_timeout got %0d want >=0", cyc); end
        n_checks++; if ({bus.result_idx, bus.result_val, bus.result_margin} !== e) begin n_fail++; $display("FAIL ovr_result got %0d %0h %0h want %0d %0h %0h", bus.result_idx, bus.result_val, bus.result_margin, e.idx, e.val, e.margin); end
        bus.done = 1'b0;
        tick();
        bus.done = 1'b1;
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        exp_count++;
        n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_ack got %0b want 1", bus.overrun); end
        n_checks++; if (bus.result_count !== 8'(exp_count)) begin n_fail++; $display("FAIL ovr_count got %0d want %0d", bus.result_count, exp_count); end
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) saw = 1'b1;
        end
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL ovr_second_result got %0b want 0", saw); end
        $display("overrun: flag=%0b count=%0d", bus.overrun, bus.result_count);
    endtask

    task automatic test_reset_mid_scan();
        bit saw;
        fire(10, 20, 30, 40);
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({bus.result_valid, bus.result_idx, bus.result_val, bus.result_margin, bus.busy, bus.overrun, bus.result_count} !== '0) begin
            n_fail++;
            $display("FAIL midscan_reset got v=%0b i=%0d val=%0h m=%0h b=%0b o=%0b c=%0d want all 0",
                     bus.result_valid, bus.result_idx, bus.result_val, bus.result_margin, bus.busy, bus.overrun, bus.result_count);
        end
        reset = 1'b0;
        sb.delete();
        exp_count = 0;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) saw = 1'b1;
        end
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL held_done_event got %0b want 0", saw); end
        $display("reset mid-scan: no result, held done ignored");
        test_classify(-1, -7, -3, -9, "after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        int   cyc;
        exp_t e;
        fire(-4, 6, 6, 2);
        wait_valid(cyc);
        e = sb.pop_front();
        n_checks++; if ({bus.result_idx, bus.result_val, bus.result_margin} !== e) begin n_fail++; $display("FAIL b2b_first got %0d %0h %0h want %0d %0h %0h", bus.result_idx, bus.result_val, bus.result_margin, e.idx, e.val, e.margin); end
        bus.result_ack = 1'b1;
        bus.done = 1'b0;
        tick();
        bus.result_ack = 1'b0;
        bus.layer_out = {32'd8, 32'd50, 32'd49, 32'd0};
        bus.done = 1'b1;
        sb.push_back(model(0, 49, 50, 8));
        tick();
        exp_count++;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %0b want 1", bus.busy); end
        wait_valid(cyc);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL b2b_latency got %0d want 4", cyc); end
        e = sb.pop_front();
        n_checks++; if ({bus.result_idx, bus.result_val, bus.result_margin} !== e) begin n_fail++; $display("FAIL b2b_second got %0d %0h %0h want %0d %0h %0h", bus.result_idx, bus.result_val, bus.result_margin, e.idx, e.val, e.margin); end
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        exp_count++;
        n_checks++; if (bus.result_count !== 8'(exp_count)) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", bus.result_count, exp_count); end
        $display("back-to-back: second idx=%0d val=%0h margin=%0h", bus.result_idx, bus.result_val, bus.result_margin);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_classify(5, -3, 12, 7, "basic", 1'b0);
        test_classify(9, 9, 1, 0, "tie", 1'b0);
        test_classify(-8, -2, -5, -2, "negative", 1'b0);
        test_classify(int'(32'h7FFF_FFFF), int'(32'h8000_0000), int'(32'h8000_0000),
                      int'(32'h8000_0000), "extremes_change", 1'b1);
        test_hold_ack();
        test_ack_idle();
        test_overrun();
        test_reset_mid_scan();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/layer_argmax.md
# layer_argmax

Output classification stage that sits directly downstream of the four-unit neural network datapath. It snapshots the final-layer neuron outputs when the network signals completion, then scans them one per cycle to find the winning unit, its value and its margin over the runner-up. It presents the result through a valid/ack handshake to the host or display logic. It also tracks completed classifications and dropped completion events.

## Interface

Parameters:
- DATA_WIDTH, 32, width of each signed two's-complement neuron output.
- NUM_UNITS, 4, number of neuron outputs scanned (≥1).
- IDX_WIDTH, 2, width of the winner index (≥ clog2(NUM_UNITS), ≥1).

Ports:
- clk  in  1  single system clock; all state is updated on its rising edge.
- reset  in  1  synchronous, active-high reset.
- done  in  1  network completion level (AND of all unit done flags).
- layer_out  in  NUM_UNITS*DATA_WIDTH  packed neuron outputs; unit i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- result_ack  in  1  consumer acknowledge.
- result_valid  out  1  result fields valid; held until acknowledged.
- result_idx  out  IDX_WIDTH  index of the winning unit.
- result_val  out  DATA_WIDTH  winning value (signed).
- result_margin  out  DATA_WIDTH  unsigned difference between the winner and the runner-up.
- busy  out  1  high in CAPTURE/SCAN/VALID.
- overrun  out  1  sticky flag: a completion event was dropped.
- result_count  out  8  completed (acknowledged) results, wraps 255→0.

## Operation

Completion detect:
- done_q is a registered copy of done; its reset value is 1.
- A done level held through reset is therefore not an event.
- An event is done=1 with done_q=0 at a clock edge.

FSM states:
- IDLE: on an event, register all of layer_out into the snapshot, set i=0, go to SCAN. Snapshot is never written outside this transition.
- SCAN: one unit per cycle, i=0..NUM_UNITS-1.
  - i=0: best=v0, second=most-negative value, idx=0.
  - i>0, v>best (signed): second=best, best=v, idx=i.
  - i>0, otherwise if v>second: second=v.
  - After unit NUM_UNITS-1, latch result_idx/val, set result_margin = best - second, go to VALID.
- VALID: result_valid=1, fields stable. On result_ack=1, go to IDLE and increment result_count.

Arithmetic:
- Comparisons are signed; the margin is computed at DATA_WIDTH+1 bits and always fits in DATA_WIDTH unsigned bits.
- Ties: the lowest index wins; the margin is 0.
- NUM_UNITS=1: margin = v0 - most-negative value.

Boundary rules:
- An event outside IDLE is dropped and sets overrun. This includes an event in the same cycle as a completing ack; it is not queued.
- result_ack outside VALID is ignored and has no side effects.
- Reset in any state (mid-scan included): return to IDLE, no result produced, all outputs cleared.
- layer_out changes after capture do not affect the result.

## Timing

- Reset values:
  - result_valid=0, result_idx=0, result_val=0, result_margin=0.
  - busy=0, overrun=0, result_count=0, state IDLE, done_q=1.
- Event sampled at edge k: snapshot taken at edge k and busy=1 after edge k.
- Units 0..NUM_UNITS-1 are processed at edges k+1..k+NUM_UNITS.
- result_valid rises after edge k+NUM_UNITS, which is 4 cycles after capture for the defaults.
- Ack sampled high at edge a: result_valid=0 and result_count incremented after edge a; busy=0 after edge a.
- Earliest next accepted event is edge a+1, which requires done to fall and rise again.
- Throughput: one result per NUM_UNITS+2 cycles minimum.
- All outputs are registered; there is no combinational path from input to output.

## Test plan

- Outputs {5, -3, 12, 7}, done rising at edge k → result_valid after edge k+4 with idx=2, val=12, margin=5; ack → result_count=1.
- Tie {9, 9, 1, 0} → idx=0, val=9, margin=0. All negative {-8, -2, -5, -2} → idx=1, val=0xFFFFFFFE, margin=0.
- Extremes {0x7FFFFFFF, 0x80000000, 0x80000000, 0x80000000} → idx=0, margin=0xFFFFFFFF. Also change layer_out during SCAN → result unchanged.
- Hold result_ack=0 for 20 cycles → result_valid and fields stable throughout; then ack → valid drops next edge. Pulse ack in IDLE → no count change.
- Drop done and re-raise it during SCAN, and again coincident with ack in VALID → overrun=1 both times, first result unaffected, no second result.
- Assert reset during SCAN → after the edge all outputs are 0 and no result appears. done held high across the reset → no event until done falls and rises again.
